rfphoenix_vec_wb_arb: RTL
=========================

Name: rfPhoenix_vec_wb_arb

Overview:
- Write-back arbiter and buffer that drives the single write port of the vector register file (wr, wthread, wmask, wa, i).
- Merges two result sources:
  - the non-stallable ALU pipe, which has default priority;
  - the variable-latency load path, buffered in a small FIFO with a starvation guard.
- All regfile write-port outputs are registered.

Parameters:
- DEPTH, 4, load FIFO entries; power of two, 2..16.
- STARVE_LIM, 8, consecutive cycles a non-empty FIFO may lose to the ALU before the ALU is stalled; 1..255.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- alu_v  in  1  ALU result valid; accepted when alu_v & ~alu_stall.
- alu_tid  in  Tid  ALU result thread.
- alu_rd  in  Regspec  ALU destination register.
- alu_mask  in  16  ALU lane write mask.
- alu_res  in  VecValue  ALU result.
- alu_stall  out  1  ALU must hold its result this cycle.
- ld_v  in  1  load result valid.
- ld_rdy  out  1  FIFO can accept; transfer when ld_v & ld_rdy.
- ld_tid  in  Tid  load result thread.
- ld_rd  in  Regspec  load destination register.
- ld_mask  in  16  load lane write mask.
- ld_res  in  VecValue  load result.
- wr  out  1  regfile write enable.
- wthread  out  Tid  regfile write thread.
- wa  out  Regspec  regfile write register.
- wmask  out  16  regfile lane mask.
- wo  out  VecValue  regfile write data (drives i).
- ld_cnt  out  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (rst low, async):
  - wr=0, wthread=0, wa=0, wmask=0, wo=0.
  - FIFO empty (ld_cnt=0), rd/wr pointers 0.
  - Starvation counter sc=0.
  - Resulting outputs: alu_stall=0, ld_rdy=1.
  - Reset mid-operation discards all buffered loads; no write is issued after rst falls.
- FIFO:
  - ld_rdy = (ld_cnt != DEPTH), combinational.
  - Push on ld_v & ld_rdy; pointers wrap modulo DEPTH.
  - Pop when the FIFO head is granted.
  - Push and pop in the same cycle leave ld_cnt unchanged.
  - A full FIFO refuses a push even if a pop occurs that cycle; ld_rdy is derived from the registered count only.
- Starve flag:
  - alu_stall = (sc == STARVE_LIM) & (ld_cnt != 0), combinational from registered state.
- Grant, evaluated each cycle, in priority order:
  1. alu_stall=1 -> FIFO head.
  2. else alu_v=1 -> ALU.
  3. else ld_cnt!=0 -> FIFO head.
  4. else none.
- Starvation counter sc:
  - Cleared to 0 when the FIFO head is granted or the FIFO is empty.
  - Incremented (saturating at STARVE_LIM) when the ALU is granted while ld_cnt!=0.
- Write-back register:
  - On any grant, the next edge loads wthread/wa/wmask/wo from the winner.
  - wr = 1 only if the winner's mask != 0.
  - A zero-mask entry still consumes its slot (ALU accepted or FIFO popped) but produces wr=0.
  - With no grant, wr=0 next cycle; the other outputs hold their values.
- Latency:
  - ALU input to wr: 1 cycle.
  - Load accepted at edge N: earliest wr at edge N+2, i.e. pop evaluated in cycle N+1.
  - No combinational path from ld_v to ld_rdy, or from alu_v to alu_stall.
- Ordering: loads leave in arrival order; ALU results are never reordered among themselves.

Test Plan:
- Reset with rst low, ld_v pulsing -> wr=0 and ld_cnt=0 held; ld_rdy=1 one cycle after rst rises.
- Single ALU result alu_v=1, tid=2, rd=5, mask=16'hFFFF, res lane0=32'h1234 -> next cycle wr=1, wthread=2, wa=5, wo lane0=32'h1234; following cycle wr=0.
- Five loads pushed back-to-back with DEPTH=4 and the ALU busy every cycle -> ld_rdy=0 after four pushes and the fifth is held; ld_cnt=4.
- Starvation with STARVE_LIM=8 (continuing the previous scenario) -> after 8 ALU wins alu_stall=1, the load head (first pushed) is written, sc=0, and alu_stall drops.
- Idle ALU with three loads queued -> three consecutive wr pulses in push order, starting 2 cycles after the first push.
- Zero-mask entry alu_mask=0 with alu_v=1 -> accepted, wr=0 next cycle; a simultaneous FIFO head is granted the following cycle.

Source files
------------

// File: rtl/rfphoenix_vec_wb_arb.sv
// rtl/rfphoenix_vec_wb_arb.sv - vector regfile write-back arbiter with buffered load path
// ALU results win by default; loads queue in a FIFO and force an ALU stall after STARVE_LIM losses.
module rfphoenix_vec_wb_arb #(
  parameter int DEPTH      = 4,
  parameter int STARVE_LIM = 8,
  parameter int TID_W      = 4,
  parameter int REG_W      = 6,
  parameter int VEC_W      = 512
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    alu_v,
  input  logic [TID_W-1:0]        alu_tid,
  input  logic [REG_W-1:0]        alu_rd,
  input  logic [15:0]             alu_mask,
  input  logic [VEC_W-1:0]        alu_res,
  output logic                    alu_stall,
  input  logic                    ld_v,
  output logic                    ld_rdy,
  input  logic [TID_W-1:0]        ld_tid,
  input  logic [REG_W-1:0]        ld_rd,
  input  logic [15:0]             ld_mask,
  input  logic [VEC_W-1:0]        ld_res,
  output logic                    wr,
  output logic [TID_W-1:0]        wthread,
  output logic [REG_W-1:0]        wa,
  output logic [15:0]             wmask,
  output logic [VEC_W-1:0]        wo,
  output logic [$clog2(DEPTH):0]  ld_cnt
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [TID_W-1:0] tid;
    logic [REG_W-1:0] rd;
    logic [15:0]      mask;
    logic [VEC_W-1:0] res;
  } entry_t;

  entry_t           mem [DEPTH];
  entry_t           head;
  logic [PTR_W-1:0] wp;
  logic [PTR_W-1:0] rp;
  logic [CNT_W-1:0] cnt;
  logic [7:0]       sc;
  logic [7:0]       sc_nxt;
  logic             fifo_ne;
  logic             push;
  logic             grant_ld;
  logic             grant_alu;

  assign head      = mem[rp];
  assign fifo_ne   = (cnt != '0);
  assign ld_rdy    = (cnt != CNT_W'(DEPTH));
  assign ld_cnt    = cnt;
  assign alu_stall = (sc == 8'(STARVE_LIM)) && fifo_ne;
  assign push      = ld_v && ld_rdy;

  // Stall forces the head out; otherwise the ALU wins and the FIFO drains only when idle.
  assign grant_ld  = alu_stall || (!alu_v && fifo_ne);
  assign grant_alu = !alu_stall && alu_v;

  always_comb begin
    sc_nxt = sc;
    if (grant_ld || !fifo_ne)
      sc_nxt = '0;
    else if (grant_alu && sc != 8'(STARVE_LIM))
      sc_nxt = sc + 8'd1;
  end

  // Payload storage carries no reset; validity is tracked by cnt alone.
  always_ff @(posedge clk) begin
    if (push)
      mem[wp] <= '{tid: ld_tid, rd: ld_rd, mask: ld_mask, res: ld_res};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
      sc  <= '0;
    end else begin
      sc <= sc_nxt;
      if (push)
        wp <= wp + PTR_W'(1);
      if (grant_ld)
        rp <= rp + PTR_W'(1);
      cnt <= cnt + CNT_W'(push) - CNT_W'(grant_ld);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr      <= 1'b0;
      wthread <= '0;
      wa      <= '0;
      wmask   <= '0;
      wo      <= '0;
    end else if (grant_alu) begin
      wr      <= (alu_mask != 16'd0);
      wthread <= alu_tid;
      wa      <= alu_rd;
      wmask   <= alu_mask;
      wo      <= alu_res;
    end else if (grant_ld) begin
      wr      <= (head.mask != 16'd0);
      wthread <= head.tid;
      wa      <= head.rd;
      wmask   <= head.mask;
      wo      <= head.res;
    end else begin
      wr      <= 1'b0;
    end
  end

endmodule
